// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS memory-access stage: access sizes,
// FSM states, writeback masks and the alignment rule.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Upper-24-bit masks that writeback ANDs onto load data.
  localparam logic [23:0] MASK_ALL  = 24'hFFFFFF;
  localparam logic [23:0] MASK_BYTE = 24'h000000;
  localparam logic [23:0] MASK_HALF = 24'h0000FF;

  // Halves need addr[0]=0; words (and the 11 encoding) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = |lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/response port. The pipeline stage is the master.
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store byte-enables and replication plus the
// misalign check on the incoming op, and load lane extract / extension /
// mask generation on the latched op. Big-endian: lane 0 is [31:24].
module mem_align
  import mips_pkg::*;
(
  input  logic [1:0]  st_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic        misaligned,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data,
  output logic [23:0] ld_mask
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Store side: enables follow the addressed lanes, data is replicated
  // across all lanes so memory can pick whichever lane is enabled.
  always_comb begin
    misaligned = is_misaligned(st_size, st_lo);
    st_be      = 4'b1111;
    st_wdata   = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b1000 >> st_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = st_lo[1] ? 4'b0011 : 4'b1100;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  // Load side: pick the lane, right-justify it, extend and pick the mask.
  always_comb begin
    case (ld_lo)
      2'd0:    byte_v = rdata[31:24];
      2'd1:    byte_v = rdata[23:16];
      2'd2:    byte_v = rdata[15:8];
      default: byte_v = rdata[7:0];
    endcase
    half_v  = ld_lo[1] ? rdata[15:0] : rdata[31:16];
    ld_data = rdata;
    ld_mask = MASK_ALL;
    case (ld_size)
      SZ_BYTE: begin
        ld_data = ld_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
        ld_mask = ld_unsigned ? MASK_BYTE : MASK_ALL;
      end
      SZ_HALF: begin
        ld_data = ld_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
        ld_mask = ld_unsigned ? MASK_HALF : MASK_ALL;
      end
      default: begin
        ld_data = rdata;
        ld_mask = MASK_ALL;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MIPS data-memory access stage: issues one req/ack memory transaction per
// load/store, stalls EX while it is outstanding, and drives MEM/WB.
module mem_access
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_nop,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        store_data,
  input  logic [1:0]         wb_in,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [1:0]         size,
  input  logic               ld_unsigned,
  mem_access_if.master       dmem,
  output logic               mem_stall,
  output logic               mem_fault,
  output logic [31:0]        datafrommem,
  output logic [31:0]        datafromimm,
  output logic [1:0]         wb,
  output logic               nop_mem,
  output logic [23:0]        datamask
);

  state_t      state;
  logic        req_q, we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, imm_q;
  logic [1:0]  wb_q, lo_q, size_q;
  logic        uns_q, rd_q;

  logic        memop, misaligned, accept;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic [23:0] ld_mask;

  mem_align u_align (
    .st_lo       (alu_result[1:0]),
    .st_size     (size),
    .st_data     (store_data),
    .misaligned  (misaligned),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_lo       (lo_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .rdata       (dmem.rdata),
    .ld_data     (ld_data),
    .ld_mask     (ld_mask)
  );

  assign memop  = memread | memwrite;
  assign accept = (state == S_IDLE) && memop && !ex_nop && !misaligned;

  // Hold EX from the accept cycle until the cycle the ack arrives.
  assign mem_stall = accept || ((state == S_BUSY) && !dmem.ack);

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.be    = be_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

  // FSM, registered memory port and MEM/WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      imm_q       <= 32'd0;
      wb_q        <= 2'd0;
      lo_q        <= 2'd0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      rd_q        <= 1'b0;
      datafrommem <= 32'd0;
      datafromimm <= 32'd0;
      wb          <= 2'd0;
      nop_mem     <= 1'b1;
      mem_fault   <= 1'b0;
      datamask    <= MASK_ALL;
    end else begin
      case (state)
        S_IDLE: begin
          mem_fault   <= 1'b0;
          datafrommem <= 32'd0;
          datamask    <= MASK_ALL;
          if (memop && !ex_nop) begin
            // Faulting or accepted mem ops both put a bubble into WB now.
            nop_mem     <= 1'b1;
            wb          <= 2'd0;
            datafromimm <= 32'd0;
            if (misaligned) begin
              mem_fault <= 1'b1;
            end else begin
              req_q   <= 1'b1;
              we_q    <= memwrite;
              be_q    <= st_be;
              addr_q  <= {alu_result[31:2], 2'b00};
              wdata_q <= st_wdata;
              imm_q   <= alu_result;
              wb_q    <= wb_in;
              lo_q    <= alu_result[1:0];
              size_q  <= size;
              uns_q   <= ld_unsigned;
              rd_q    <= memread;
              state   <= S_BUSY;
            end
          end else begin
            datafromimm <= alu_result;
            wb          <= wb_in;
            nop_mem     <= ex_nop;
          end
        end
        S_BUSY: begin
          mem_fault <= 1'b0;
          if (dmem.ack) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= 4'd0;
            datafrommem <= rd_q ? ld_data : 32'd0;
            datamask    <= rd_q ? ld_mask : MASK_ALL;
            datafromimm <= imm_q;
            wb          <= wb_q;
            nop_mem     <= 1'b0;
            state       <= S_IDLE;
          end else begin
            datafrommem <= 32'd0;
            datafromimm <= 32'd0;
            datamask    <= MASK_ALL;
            wb          <= 2'd0;
            nop_mem     <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a byte-addressed memory model answers
// requests with a chosen latency; expected requests and WB results are
// queued at issue time and checked by separate monitor processes.
module tb_mem_access;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_nop;
  logic [31:0] alu_result, store_data;
  logic [1:0]  wb_in, size;
  logic        memread, memwrite, ld_unsigned;
  logic        mem_stall, mem_fault, nop_mem;
  logic [31:0] datafrommem, datafromimm;
  logic [1:0]  wb;
  logic [23:0] datamask;

  mem_access_if dmem ();

  mem_access dut (
    .clk         (clk),
    .reset       (reset),
    .ex_nop      (ex_nop),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .wb_in       (wb_in),
    .memread     (memread),
    .memwrite    (memwrite),
    .size        (size),
    .ld_unsigned (ld_unsigned),
    .dmem        (dmem),
    .mem_stall   (mem_stall),
    .mem_fault   (mem_fault),
    .datafrommem (datafrommem),
    .datafromimm (datafromimm),
    .wb          (wb),
    .nop_mem     (nop_mem),
    .datamask    (datamask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    logic        nop;
    logic        chk_imm;
    logic        chk_data;
    logic [31:0] dfm;
    logic [31:0] dfi;
    logic [1:0]  wbv;
    logic [23:0] mask;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } rq_exp_t;

  wb_exp_t     wbq[$];
  rq_exp_t     rqq[$];
  logic [7:0]  mem [0:1023];
  int          errors = 0;
  int          checks = 0;
  int          resp_delay = 0;
  bit          hold = 1'b0;
  logic        late_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks resp_delay cycles after req is first seen.
  initial begin
    int  cnt;
    bit  seen;
    cnt = 0;
    seen = 1'b0;
    dmem.ack = 1'b0;
    dmem.rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (hold) begin
        dmem.ack = late_ack;
        seen = 1'b0;
      end else begin
        dmem.ack = 1'b0;
        if (dmem.req === 1'b1) begin
          if (!seen) begin
            rq_exp_t r;
            seen = 1'b1;
            cnt = resp_delay;
            if (rqq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_req: got addr %h expected none", dmem.addr);
            end else begin
              r = rqq.pop_front();
              chk("req_we", {31'd0, dmem.we}, {31'd0, r.we});
              chk("req_addr", dmem.addr, r.addr);
              chk("req_be", {28'd0, dmem.be}, {28'd0, r.be});
              if (r.we) chk("req_wdata", dmem.wdata, r.wdata);
            end
          end
          if (cnt == 0) begin
            int base;
            base = int'(dmem.addr[9:0]);
            dmem.rdata = {mem[base], mem[base+1], mem[base+2], mem[base+3]};
            if (dmem.we) begin
              for (int i = 0; i < 4; i++)
                if (dmem.be[3-i]) mem[base+i] = dmem.wdata[31-8*i -: 8];
            end
            dmem.ack = 1'b1;
            seen = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // WB monitor: any non-bubble or fault output must match the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (nop_mem !== 1'b1 || mem_fault !== 1'b0) begin
        if (wbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: got nop_mem=%b fault=%b expected none", nop_mem, mem_fault);
        end else begin
          wb_exp_t e;
          e = wbq.pop_front();
          chk("wb_fault", {31'd0, mem_fault}, {31'd0, e.fault});
          chk("wb_nop", {31'd0, nop_mem}, {31'd0, e.nop});
          if (e.chk_imm) begin
            chk("wb_dfi", datafromimm, e.dfi);
            chk("wb_wb", {30'd0, wb}, {30'd0, e.wbv});
          end
          if (e.chk_data) begin
            chk("wb_dfm", datafrommem, e.dfm);
            chk("wb_mask", {8'd0, datamask}, {8'd0, e.mask});
          end
        end
      end
    end
  end

  // Present one op, queue its expectations, hold it until no stall.
  task automatic issue(input bit nop, input bit rd, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a, input logic [31:0] sd,
                       input logic [1:0] wbi, input int d);
    int nbytes, lo, stalls, exp_stalls;
    bit mis, s;
    wb_exp_t e;
    rq_exp_t r;
    logic [31:0] v;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lo     = int'(a[1:0]);
    mis    = (nbytes == 2 && a[0]) || (nbytes == 4 && a[1:0] != 2'd0);
    e = '{fault:1'b0, nop:1'b0, chk_imm:1'b1, chk_data:1'b1, dfm:32'd0, dfi:a,
          wbv:wbi, mask:24'hFFFFFF};
    exp_stalls = 0;
    if (nop || !(rd || wr)) begin
      if (!nop) wbq.push_back(e);
    end else if (mis) begin
      e.fault = 1'b1; e.nop = 1'b1; e.chk_imm = 1'b0; e.chk_data = 1'b0;
      wbq.push_back(e);
    end else begin
      r.we = wr;
      r.addr = {a[31:2], 2'b00};
      r.be = 4'd0;
      for (int i = 0; i < 4; i++)
        if (i >= (nbytes == 4 ? 0 : lo) && i < (nbytes == 4 ? 0 : lo) + nbytes) r.be[3-i] = 1'b1;
      r.wdata = (nbytes == 1) ? {4{sd[7:0]}} : (nbytes == 2) ? {2{sd[15:0]}} : sd;
      rqq.push_back(r);
      if (rd) begin
        v = 32'd0;
        for (int i = 0; i < nbytes; i++) v = (v << 8) | {24'd0, mem[int'(a[9:0]) + i]};
        if (nbytes < 4 && !uns && v[8*nbytes-1]) v = v | (32'hFFFFFFFF << (8*nbytes));
        e.dfm = v;
        e.mask = (nbytes == 4 || !uns) ? 24'hFFFFFF : (nbytes == 1) ? 24'h000000 : 24'h0000FF;
      end else begin
        e.chk_data = 1'b0;
      end
      wbq.push_back(e);
      exp_stalls = d + 1;
    end
    resp_delay = d;
    ex_nop = nop; memread = rd; memwrite = wr; size = sz; ld_unsigned = uns;
    alu_result = a; store_data = sd; wb_in = wbi;
    stalls = 0;
    forever begin
      @(negedge clk);
      s = mem_stall;
      @(posedge clk);
      #1;
      if (!s) break;
      stalls++;
      if (stalls > 50) begin
        checks++; errors++;
        $display("FAIL stall_timeout: got %0d stall cycles expected %0d", stalls, exp_stalls);
        break;
      end
    end
    chk("stall_cycles", stalls, exp_stalls);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    reset = 1'b1; ex_nop = 1'b1; memread = 1'b0; memwrite = 1'b0; size = 2'd0;
    ld_unsigned = 1'b0; alu_result = 32'd0; store_data = 32'd0; wb_in = 2'd0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", {31'd0, dmem.req}, 32'd0);
    chk("rst_nop", {31'd0, nop_mem}, 32'd1);
    chk("rst_mask", {8'd0, datamask}, 32'h00FFFFFF);
    chk("rst_wb", {30'd0, wb}, 32'd0);
    reset = 1'b0;

    // Directed cases
    issue(0, 0, 0, 2'd2, 0, 32'h12345678, 32'd0, 2'b10, 0);
    {mem[256], mem[257], mem[258], mem[259]} = 32'hDEADBEEF;
    issue(0, 1, 0, 2'd2, 0, 32'h100, 32'd0, 2'b11, 2);
    {mem[256], mem[257], mem[258], mem[259]} = 32'h000000F0;
    issue(0, 1, 0, 2'd0, 0, 32'h103, 32'd0, 2'b11, 1);
    issue(0, 1, 0, 2'd0, 1, 32'h103, 32'd0, 2'b11, 0);
    issue(0, 0, 1, 2'd1, 0, 32'h22, 32'hAAAA1234, 2'b00, 1);
    issue(0, 1, 0, 2'd2, 0, 32'h101, 32'd0, 2'b11, 0);
    issue(1, 1, 0, 2'd2, 0, 32'h104, 32'd0, 2'b11, 0);

    // Randomized ops
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [1:0] sz;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 1019));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz != 2'd0) a[1:0] = 2'd0;
      end
      if (kind < 2)
        issue(0, 0, 0, sz, 0, $urandom, $urandom, 2'($urandom), 0);
      else if (kind < 3)
        issue(1, $urandom_range(0, 1) == 1, 0, sz, 0, a, $urandom, 2'($urandom), 0);
      else if (kind < 6)
        issue(0, 0, 1, sz, 0, a, $urandom, {1'b0, 1'($urandom)}, int'($urandom_range(0, 3)));
      else
        issue(0, 1, 0, sz, 1'($urandom), a, 32'd0, 2'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset while BUSY; a later ack must not write WB.
    hold = 1'b1;
    ex_nop = 1'b0; memread = 1'b1; memwrite = 1'b0; size = 2'd2; alu_result = 32'h40;
    @(posedge clk); #1;
    ex_nop = 1'b1; memread = 1'b0;
    @(posedge clk); #1;
    chk("busy_req", {31'd0, dmem.req}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_req", {31'd0, dmem.req}, 32'd0);
    chk("mid_rst_we", {31'd0, dmem.we}, 32'd0);
    chk("mid_rst_be", {28'd0, dmem.be}, 32'd0);
    chk("mid_rst_nop", {31'd0, nop_mem}, 32'd1);
    chk("mid_rst_dfm", datafrommem, 32'd0);
    chk("mid_rst_dfi", datafromimm, 32'd0);
    chk("mid_rst_mask", {8'd0, datamask}, 32'h00FFFFFF);
    @(negedge clk); late_ack = 1'b1;
    @(negedge clk); late_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
      chk("late_ack_nop", {31'd0, nop_mem}, 32'd1);
      chk("late_ack_req", {31'd0, dmem.req}, 32'd0);
    end
    hold = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("wbq_drained", wbq.size(), 32'd0);
    chk("rqq_drained", rqq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
